enet_gmii_rx_frame: RTL

//  GMII receive framer, directly downstream of the RGMII->GMII RX converter, on gmii_rx_clk.

---
 rtl/enet_gmii_rx_frame.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/enet_gmii_rx_frame.sv
// enet_gmii_rx_frame
// GMII receive framer. It strips the preamble and SFD, checks the CRC-32 and the frame length,
// and emits frame bytes with the 4 FCS bytes removed. A 5-byte delay line holds back the
// trailing FCS, so the last emitted byte is known to be the last payload byte when dv drops.
// There is no backpressure: the consumer must accept every beat.
module enet_gmii_rx_frame #(
  parameter int MIN_PREAMBLE = 1,
  parameter int MIN_FRAME    = 64,
  parameter int MAX_FRAME    = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  output logic        m_valid,
  output logic [7:0]  m_data,
  output logic        m_sop,
  output logic        m_eop,
  output logic [3:0]  m_err,
  output logic [15:0] m_len,
  output logic        stat_good,
  output logic        stat_drop
);

  localparam logic [2:0]  MIN_PRE_L   = 3'(MIN_PREAMBLE);
  localparam logic [15:0] MIN_FRM_L   = 16'(MIN_FRAME);
  localparam logic [15:0] MAX_FRM_L   = 16'(MAX_FRAME);
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  // Register value left behind after running the CRC over a frame that includes a correct FCS
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [7:0]  PRE_BYTE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DROP
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [2:0]      r_pcnt;
  logic [2:0]      w_pcnt_next;
  logic [15:0]     r_bcnt;
  logic [15:0]     w_bcnt_next;
  logic [31:0]     r_crc;
  logic [31:0]     w_crc_next;
  logic            r_er_flag;
  logic            w_er_flag_next;
  // Delay line: index 0 is the newest byte, index 4 the oldest
  logic [4:0][7:0] r_sr;
  logic [4:0][7:0] w_sr_next;

  logic            w_frame_start;
  logic            w_sr_full;
  logic            w_first_beat;
  logic [3:0]      w_end_flags;

  logic            w_valid_next;
  logic [7:0]      w_data_next;
  logic            w_sop_next;
  logic            w_eop_next;
  logic [3:0]      w_err_next;
  logic [15:0]     w_len_next;
  logic            w_good_next;
  logic            w_drop_next;

  // Reflected CRC-32 update, one byte, LSB first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // The delay line is full once five frame bytes have been received
  assign w_sr_full    = (r_bcnt >= 16'd5);
  // bcnt only passes through 5 once per frame, so this marks the frame's first beat
  assign w_first_beat = (r_bcnt == 16'd5);
  // Status flags at frame end: {rx_er_seen, crc_bad, runt, oversize}
  assign w_end_flags  = {r_er_flag,
                         (r_crc != CRC_RESIDUE),
                         (r_bcnt < MIN_FRM_L),
                         (r_bcnt > MAX_FRM_L)};

  // Next-state, datapath and output-beat decode
  always_comb begin
    w_state_next   = r_state;
    w_pcnt_next    = r_pcnt;
    w_bcnt_next    = r_bcnt;
    w_crc_next     = r_crc;
    w_er_flag_next = r_er_flag;
    w_sr_next      = r_sr;
    w_frame_start  = 1'b0;
    w_valid_next   = 1'b0;
    w_data_next    = 8'h00;
    w_sop_next     = 1'b0;
    w_eop_next     = 1'b0;
    w_err_next     = 4'h0;
    w_len_next     = 16'h0000;
    w_good_next    = 1'b0;
    w_drop_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        // rx_er without dv is a carrier event, not part of a frame: ignored here
        if (gmii_rx_dv) begin
          if (gmii_rxd == PRE_BYTE) begin
            w_state_next = S_PRE;
            w_pcnt_next  = 3'd1;
          end else if ((gmii_rxd == SFD_BYTE) && (MIN_PRE_L == 3'd0)) begin
            w_state_next  = S_DATA;
            w_frame_start = 1'b1;
          end else begin
            w_state_next = S_DROP;
          end
        end
      end

      S_PRE: begin
        if (!gmii_rx_dv) begin
          w_state_next = S_IDLE;
        end else if (gmii_rxd == PRE_BYTE) begin
          w_pcnt_next = (r_pcnt == 3'd7) ? r_pcnt : (r_pcnt + 3'd1);
        end else if ((gmii_rxd == SFD_BYTE) && (r_pcnt >= MIN_PRE_L)) begin
          w_state_next  = S_DATA;
          w_frame_start = 1'b1;
        end else begin
          // Short preamble before SFD, or a corrupt preamble byte
          w_state_next = S_DROP;
          w_drop_next  = 1'b1;
        end
      end

      S_DATA: begin
        if (gmii_rx_dv) begin
          w_sr_next      = {r_sr[3:0], gmii_rxd};
          w_crc_next     = crc32_byte(r_crc, gmii_rxd);
          w_bcnt_next    = (r_bcnt == 16'hFFFF) ? r_bcnt : (r_bcnt + 16'd1);
          w_er_flag_next = r_er_flag | gmii_rx_er;
          if (w_sr_full) begin
            w_valid_next = 1'b1;
            w_data_next  = r_sr[4];
            w_sop_next   = w_first_beat;
          end
        end else begin
          w_state_next = S_IDLE;
          if (w_sr_full) begin
            // The four newest bytes are the FCS; the oldest is the last payload byte
            w_valid_next = 1'b1;
            w_data_next  = r_sr[4];
            w_sop_next   = w_first_beat;
            w_eop_next   = 1'b1;
            w_len_next   = r_bcnt - 16'd4;
            w_err_next   = w_end_flags;
            w_good_next  = (w_end_flags == 4'h0);
          end else begin
            // Too short to hold an FCS: nothing was emitted, so count it as dropped
            w_drop_next = 1'b1;
          end
        end
      end

      S_DROP: begin
        if (!gmii_rx_dv) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Every entry into DATA starts a fresh frame context
    if (w_frame_start) begin
      w_crc_next     = CRC_INIT;
      w_bcnt_next    = 16'h0000;
      w_sr_next      = '0;
      w_er_flag_next = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Preamble counter, byte counter, CRC, error flag and delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt    <= 3'd0;
      r_bcnt    <= 16'h0000;
      r_crc     <= CRC_INIT;
      r_er_flag <= 1'b0;
      r_sr      <= '0;
    end else begin
      r_pcnt    <= w_pcnt_next;
      r_bcnt    <= w_bcnt_next;
      r_crc     <= w_crc_next;
      r_er_flag <= w_er_flag_next;
      r_sr      <= w_sr_next;
    end
  end

  // Registered output beat and status pulses; all fields return to zero between beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      m_data    <= 8'h00;
      m_sop     <= 1'b0;
      m_eop     <= 1'b0;
      m_err     <= 4'h0;
      m_len     <= 16'h0000;
      stat_good <= 1'b0;
      stat_drop <= 1'b0;
    end else begin
      m_valid   <= w_valid_next;
      m_data    <= w_data_next;
      m_sop     <= w_sop_next;
      m_eop     <= w_eop_next;
      m_err     <= w_err_next;
      m_len     <= w_len_next;
      stat_good <= w_good_next;
      stat_drop <= w_drop_next;
    end
  end

endmodule
